// File: rtl/wisc_pkg.sv
// Shared WISC pipeline types and constants.
// Used by the IF/ID/EX stage blocks and the pipeline controller.
package wisc_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } ctrl_state_t;

  localparam int          HALT_DRAIN_DEF = 3;
  localparam logic [15:0] NOP            = 16'h0000;
  localparam logic [15:0] CNT_MAX        = 16'hFFFF;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// RAW hazard check of the ID sources against EX/MEM writers.
// WB is excluded: the register file writes before it reads.
module hazard_detect (
  input  logic [3:0] id_rs,
  input  logic [3:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_reg_write,
  input  logic [3:0] ex_reg_rd,
  input  logic       mem_reg_write,
  input  logic [3:0] mem_reg_rd,
  output logic       hazard
);

  function automatic logic src_hit(
    input logic       used,
    input logic [3:0] src,
    input logic       exw,
    input logic [3:0] exd,
    input logic       memw,
    input logic [3:0] memd
  );
    return used && (src != 4'd0) &&
           ((exw && exd == src) ||
            (memw && memd == src));
  endfunction

  assign hazard =
    src_hit(id_uses_rs, id_rs, ex_reg_write,
            ex_reg_rd, mem_reg_write, mem_reg_rd) ||
    src_hit(id_uses_rt, id_rt, ex_reg_write,
            ex_reg_rd, mem_reg_write, mem_reg_rd);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall/flush decisions, RET and HLT sequencing,
// and saturating stall/flush statistics.
module pipeline_ctrl
  import wisc_pkg::*;
#(
  parameter int HALT_DRAIN = HALT_DRAIN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_ret,
  input  logic        id_hlt,
  input  logic        ex_reg_write,
  input  logic [3:0]  ex_reg_rd,
  input  logic        mem_reg_write,
  input  logic [3:0]  mem_reg_rd,
  input  logic        ex_pc_src,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int DW = $clog2(HALT_DRAIN + 1);

  ctrl_state_t   cur;
  logic [DW-1:0] drain_cnt;
  logic          hazard;
  logic          stall_evt;
  logic          flush_evt;

  hazard_detect u_hazard (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .ex_reg_write  (ex_reg_write),
    .ex_reg_rd     (ex_reg_rd),
    .mem_reg_write (mem_reg_write),
    .mem_reg_rd    (mem_reg_rd),
    .hazard        (hazard)
  );

  assign state = cur;

  // Outputs are forced low while rst is held, whatever the state.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    if (!rst) begin
      unique case (cur)
        RUN: begin
          if (ex_pc_src) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_evt   = 1'b1;
          end else if (hazard) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            stall_evt   = 1'b1;
          end
        end
        RET_WAIT: begin
          pc_hold    = 1'b1;
          ifid_flush = 1'b1;
          if (ex_pc_src) begin
            idex_bubble = 1'b1;
            flush_evt   = 1'b1;
          end
        end
        DRAIN: begin
          pc_hold    = 1'b1;
          ifid_flush = 1'b1;
        end
        HALTED: begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          halted      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
      if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
      unique case (cur)
        RUN: begin
          if (!ex_pc_src && !hazard) begin
            if (id_ret) begin
              cur <= RET_WAIT;
            end else if (id_hlt) begin
              drain_cnt <= DW'(HALT_DRAIN - 1);
              cur       <= DRAIN;
            end
          end
        end
        RET_WAIT: begin
          if (ex_pc_src) cur <= RUN;
        end
        DRAIN: begin
          if (drain_cnt == '0) cur <= HALTED;
          else drain_cnt <= drain_cnt - DW'(1);
        end
        HALTED: cur <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios,
// random traffic and counter saturation against a behavioural model.
module tb_pipeline_ctrl;

  localparam int HD = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt;
  logic        id_ret, id_hlt;
  logic        ex_reg_write, mem_reg_write;
  logic [3:0]  ex_reg_rd, mem_reg_rd;
  logic        ex_pc_src;
  logic        pc_hold, ifid_hold, ifid_flush, idex_bubble;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int npass = 0;
  int ntot  = 0;

  pipeline_ctrl #(.HALT_DRAIN(HD)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_ret        (id_ret),
    .id_hlt        (id_hlt),
    .ex_reg_write  (ex_reg_write),
    .ex_reg_rd     (ex_reg_rd),
    .mem_reg_write (mem_reg_write),
    .mem_reg_rd    (mem_reg_rd),
    .ex_pc_src     (ex_pc_src),
    .pc_hold       (pc_hold),
    .ifid_hold     (ifid_hold),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .halted        (halted),
    .state         (state),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h expected=%0h @%0t",
                  name, got, exp, $time);
  endtask

  // Model: mode 0=running, 1=waiting for RET target,
  // 2=draining (m_left cycles remain), 3=halted.
  int m_mode, m_left, m_stall, m_flush;

  function automatic bit hit(input bit used, input logic [3:0] r);
    return used && r != 0 &&
           ((ex_reg_write && ex_reg_rd == r) ||
            (mem_reg_write && mem_reg_rd == r));
  endfunction

  function automatic bit hz();
    return hit(id_uses_rs, id_rs) || hit(id_uses_rt, id_rt);
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  <= 0;
      m_left  <= 0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      case (m_mode)
        0: if (ex_pc_src) m_flush <= sat(m_flush);
           else if (hz()) m_stall <= sat(m_stall);
           else if (id_ret) m_mode <= 1;
           else if (id_hlt) begin
             m_mode <= 2;
             m_left <= HD;
           end
        1: if (ex_pc_src) begin
             m_flush <= sat(m_flush);
             m_mode  <= 0;
           end
        2: begin
             m_left <= m_left - 1;
             if (m_left == 1) m_mode <= 3;
           end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    bit e_ph, e_ih, e_if, e_ib, e_h;
    e_ph = 0; e_ih = 0; e_if = 0; e_ib = 0; e_h = 0;
    if (!rst) begin
      case (m_mode)
        0: if (ex_pc_src) begin e_if = 1; e_ib = 1; end
           else if (hz()) begin e_ph = 1; e_ih = 1; e_ib = 1; end
        1: begin e_ph = 1; e_if = 1; e_ib = ex_pc_src; end
        2: begin e_ph = 1; e_if = 1; end
        default: begin e_ph = 1; e_ih = 1; e_ib = 1; e_h = 1; end
      endcase
    end
    chk("pc_hold", pc_hold, e_ph);
    chk("ifid_hold", ifid_hold, e_ih);
    chk("ifid_flush", ifid_flush, e_if);
    chk("idex_bubble", idex_bubble, e_ib);
    chk("halted", halted, e_h);
    chk("state", state, rst ? 0 : m_mode);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
  end

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_ret = 0; id_hlt = 0; ex_pc_src = 0;
    ex_reg_write = 0; ex_reg_rd = 0;
    mem_reg_write = 0; mem_reg_rd = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_pc_hold", pc_hold, 0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("run_state", state, 0);

    step();
    id_uses_rs = 1; id_rs = 3; ex_reg_write = 1; ex_reg_rd = 3;
    @(negedge clk);
    chk("ex_stall_hold", pc_hold, 1);
    chk("ex_stall_ifid", ifid_hold, 1);
    chk("ex_stall_bub", idex_bubble, 1);
    step();
    ex_reg_write = 0; mem_reg_write = 1; mem_reg_rd = 3;
    @(negedge clk);
    chk("mem_stall_hold", pc_hold, 1);
    step();
    mem_reg_write = 0;
    @(negedge clk);
    chk("stall_clear", pc_hold, 0);
    chk("stall_cnt_2", stall_cnt, 2);

    step();
    id_rs = 0; ex_reg_write = 1; ex_reg_rd = 0;
    @(negedge clk);
    chk("r0_no_stall", pc_hold, 0);
    step();
    id_uses_rs = 0; id_uses_rt = 0; id_rt = 5; ex_reg_rd = 5;
    @(negedge clk);
    chk("rt_unused", pc_hold, 0);

    step();
    id_uses_rt = 1; ex_pc_src = 1;
    @(negedge clk);
    chk("pri_flush", ifid_flush, 1);
    chk("pri_bubble", idex_bubble, 1);
    chk("pri_no_hold", pc_hold, 0);
    step(); idle();
    @(negedge clk);
    chk("pri_flush_cnt", flush_cnt, 1);
    chk("pri_stall_cnt", stall_cnt, 2);

    step(); id_ret = 1;
    @(negedge clk);
    chk("ret_in_run", state, 0);
    step(); idle();
    @(negedge clk);
    chk("ret_wait_1", state, 1);
    chk("ret_wait_hold", pc_hold, 1);
    step(); ex_pc_src = 1;
    @(negedge clk);
    chk("ret_wait_2", state, 1);
    chk("ret_wait_bub", idex_bubble, 1);
    step(); idle();
    @(negedge clk);
    chk("ret_back_run", state, 0);
    chk("ret_flush_cnt", flush_cnt, 2);

    step(); id_hlt = 1;
    @(negedge clk);
    chk("hlt_in_run", state, 0);
    for (int i = 0; i < HD; i++) begin
      step(); idle(); ex_pc_src = (i == 0);
      @(negedge clk);
      chk("drain_state", state, 2);
      chk("drain_not_halt", halted, 0);
    end
    step(); idle();
    @(negedge clk);
    chk("halted_state", state, 3);
    chk("halted_flag", halted, 1);

    #2 rst = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_stall", stall_cnt, 0);
    chk("async_flush", flush_cnt, 0);
    chk("async_halted", halted, 0);
    chk("async_hold", pc_hold, 0);
    step(); step(); rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      step();
      if (rst) rst = 1'b0;
      else if (m_mode == 3 || $urandom_range(199) == 0) rst = 1'b1;
      id_rs         = 4'($urandom_range(3));
      id_rt         = 4'($urandom_range(3));
      id_uses_rs    = 1'($urandom_range(1));
      id_uses_rt    = 1'($urandom_range(1));
      ex_reg_write  = ($urandom_range(3) == 0);
      ex_reg_rd     = 4'($urandom_range(3));
      mem_reg_write = ($urandom_range(3) == 0);
      mem_reg_rd    = 4'($urandom_range(3));
      ex_pc_src     = ($urandom_range(6) == 0);
      id_ret        = ($urandom_range(11) == 0);
      id_hlt        = !id_ret && ($urandom_range(29) == 0);
    end

    step(); idle(); rst = 1'b1;
    step(); rst = 1'b0;
    id_uses_rs = 1; id_rs = 1; ex_reg_write = 1; ex_reg_rd = 1;
    @(negedge clk);
    for (int n = 0; n < 65534; n++) step();
    @(negedge clk);
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    repeat (3) step();
    @(negedge clk);
    chk("sat_ffff", stall_cnt, 16'hFFFF);

    step(); idle();
    @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  core clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: id_rs, id_rt  in  4 each  source registers of the instruction in ID.
REQ-004 SHALL have ports: id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-005 SHALL have ports: id_ret, id_hlt  in  1 each  ID holds RET / HLT.
REQ-006 SHALL have ports: ex_reg_write, ex_reg_rd  in  1, 4  EX-stage writer valid and destination.
REQ-007 SHALL have ports: mem_reg_write, mem_reg_rd  in  1, 4  MEM-stage writer valid and destination.
REQ-008 SHALL have ports: ex_pc_src  in  1  EX redirects PC (taken branch, call, ret).
REQ-009 SHALL have ports: pc_hold, ifid_hold  out  1 each  freeze PC and the IF/ID register.
REQ-010 SHALL have ports: ifid_flush, idex_bubble  out  1 each  load NOP into IF/ID and ID/EX.
REQ-011 SHALL have ports: halted  out  1; state  out  2; stall_cnt, flush_cnt  out  16 each.
REQ-012 SHALL have parameter HALT_DRAIN, default 3, meaning cycles from HLT leaving ID to halted.

Function
REQ-013 hazard SHALL be asserted when a used ID source equals a valid EX or MEM destination, with register 0 never matching; WB-stage conflicts are excluded because the register file writes before it reads.
REQ-014 FSM states SHALL be RUN=0, RET_WAIT=1, DRAIN=2, HALTED=3, and state SHALL show the current state.
REQ-015 Control outputs SHALL be combinational from the current state and inputs. The FSM and counters SHALL be registered.
REQ-016 In RUN, priority SHALL be: ex_pc_src, then hazard, then id_ret/id_hlt.
REQ-017 RUN with ex_pc_src SHALL drive ifid_flush=1 and idex_bubble=1 for that cycle, increment flush_cnt, and stay in RUN. Any id_hlt/id_ret that cycle is squashed.
REQ-018 RUN with hazard SHALL drive pc_hold=1, ifid_hold=1 and idex_bubble=1, increment stall_cnt, and stay in RUN. The hold repeats each cycle until the hazard clears.
REQ-019 RUN with id_ret and no hazard SHALL let RET proceed to EX and go to RET_WAIT.
REQ-020 RUN with id_hlt and no hazard SHALL let HLT proceed, load the drain counter with HALT_DRAIN-1 and go to DRAIN.
REQ-021 RET_WAIT SHALL drive pc_hold=1 and ifid_flush=1 every cycle.
REQ-022 RET_WAIT with ex_pc_src SHALL additionally drive idex_bubble=1, increment flush_cnt and return to RUN.
REQ-023 DRAIN SHALL drive pc_hold=1 and ifid_flush=1 and decrement the counter. At counter 0 it SHALL go to HALTED. ex_pc_src is ignored in DRAIN.
REQ-024 HALTED SHALL drive pc_hold=1, ifid_hold=1, idex_bubble=1 and halted=1, and leave only on rst.
REQ-025 stall_cnt and flush_cnt SHALL saturate at 0xFFFF and never wrap.
REQ-026 All outputs not asserted by a rule above SHALL be 0.

Reset
REQ-027 rst SHALL asynchronously force state=RUN, drain counter=0, stall_cnt=0 and flush_cnt=0.
REQ-028 During rst all control outputs and halted SHALL be 0, including when rst is asserted mid-stall, mid-RET_WAIT or mid-DRAIN.
REQ-029 Operation SHALL resume in RUN on the first rising edge after rst deasserts.

Structure
REQ-030 The state enum, HALT_DRAIN default and NOP encoding SHALL live in a shared wisc_pkg, reused by the IF/ID/EX stage blocks.
REQ-031 Hazard comparison SHALL be a separate combinational sub-module, hazard_detect.
REQ-032 The FSM, drain counter and statistics counters SHALL reside in pipeline_ctrl.

Verification
REQ-033 ID rs=3 and EX writer rd=3 valid for one cycle then moving to MEM -> pc_hold/ifid_hold/idex_bubble high 2 cycles, stall_cnt=2.
REQ-034 ID rs=0 and EX rd=0 valid -> no stall. ID id_uses_rt=0 with rt=EX rd -> no stall.
REQ-035 ex_pc_src and hazard in the same cycle -> ifid_flush=1, idex_bubble=1, pc_hold=0, flush_cnt+1, stall_cnt unchanged.
REQ-036 id_ret, then ex_pc_src 2 cycles later -> RET_WAIT for 2 cycles with pc_hold=1, then RUN.
REQ-037 id_hlt with no hazard -> DRAIN for 3 cycles, then halted=1. Asserting rst in HALTED -> state=0 and counters=0 immediately, without waiting for a clock edge.
REQ-038 Force stall_cnt to 0xFFFE and hold a hazard for 3 cycles -> stall_cnt=0xFFFF with no wrap.
